// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
// N-digit seven-segment display controller. A hex value and per-digit
// blank/blink masks are captured into a shadow register on iLOAD. The
// captured value is then decoded into two registered output forms:
//   * oSEG: static segments for every digit at once.
//   * oSCAN_SEG/oSCAN_AN: a time-multiplexed scan bus that drives one
//     digit at a time.
// Decoding supports leading-zero suppression and timed blinking.
// Segment codes are active-low, with bit0=a through bit6=g.
//
// Optional build macro SEG7_DP_EN adds a decimal-point input iDP.
// It also widens every segment field to 8 bits, with bit7 = dp (active-low).
//
// Load interface: iLOAD is a single-cycle capture strobe with no back-pressure.
// The design always accepts it. New data reaches oSEG one edge after the
// capturing edge. Without iLOAD, changes on iDIG/iBLANK/iBLINK/iDP are ignored.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iLOAD,
    input  logic [4*NUM_DIGITS-1:0] iDIG,
    input  logic [NUM_DIGITS-1:0]   iBLANK,
    input  logic [NUM_DIGITS-1:0]   iBLINK,
    input  logic                    iLZ_EN,
`ifdef SEG7_DP_EN
    input  logic [NUM_DIGITS-1:0]   iDP,
    output logic [8*NUM_DIGITS-1:0] oSEG,
    output logic [7:0]              oSCAN_SEG,
`else
    output logic [7*NUM_DIGITS-1:0] oSEG,
    output logic [6:0]              oSCAN_SEG,
`endif
    output logic [NUM_DIGITS-1:0]   oSCAN_AN
);

`ifdef SEG7_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Shadow copy of the display contents
    logic [4*NUM_DIGITS-1:0] shadowDig;
    logic [NUM_DIGITS-1:0]   shadowBlank;
    logic [NUM_DIGITS-1:0]   shadowBlink;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   shadowDp;
`endif

    // Timebases
    logic [BLINK_W-1:0] blinkCnt;
    logic               blinkPhase;
    logic [SCAN_W-1:0]  scanCnt;
    logic [IDX_W-1:0]   scanIdx;

    // Combinational next values for the output registers
    logic [NUM_DIGITS-1:0]       lzMask;
    logic [SEG_W*NUM_DIGITS-1:0] segNext;
    logic [SEG_W-1:0]            scanSegNext;
    logic [NUM_DIGITS-1:0]       anNext;

    // Hex nibble to active-low a..g pattern
    function automatic logic [6:0] hexToSeg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Capture inputs into the shadow register on the load strobe; reset wins
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shadowDig   <= '0;
            shadowBlank <= '1;
            shadowBlink <= '0;
`ifdef SEG7_DP_EN
            shadowDp    <= '0;
`endif
        end else if (iLOAD) begin
            shadowDig   <= iDIG;
            shadowBlank <= iBLANK;
            shadowBlink <= iBLINK;
`ifdef SEG7_DP_EN
            shadowDp    <= iDP;
`endif
        end
    end

    // Free-running blink timebase; the phase toggles on each counter wrap
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else if (blinkCnt == BLINK_LAST) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    // Scan timebase; the digit index advances once per slot and wraps at the top digit
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            scanCnt <= '0;
            scanIdx <= '0;
        end else if (scanCnt == SCAN_LAST) begin
            scanCnt <= '0;
            if (scanIdx == IDX_LAST) begin
                scanIdx <= '0;
            end else begin
                scanIdx <= scanIdx + 1'b1;
            end
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    // Leading-zero mask. Walk down from the top digit while digits are zero.
    // Digit 0 is never included, so a value of zero still shows one "0".
    always_comb begin
        logic leading;
        lzMask  = '0;
        leading = 1'b1;
        for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
            if (leading && (shadowDig[4*n +: 4] == 4'h0)) begin
                lzMask[n] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end

    // Final per-digit code.
    // Priority: forced blank > blink-off > LZ suppression > decode.
    // The dp bit follows blank and blink only, never LZ suppression.
    always_comb begin
        logic       hardOff;
        logic       segOff;
        logic [6:0] seg7;
        segNext = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            hardOff = shadowBlank[n] | (blinkPhase & shadowBlink[n]);
            segOff  = hardOff | (iLZ_EN & lzMask[n]);
            seg7    = segOff ? SEG_OFF : hexToSeg(shadowDig[4*n +: 4]);
`ifdef SEG7_DP_EN
            segNext[SEG_W*n +: SEG_W] = {(hardOff | ~shadowDp[n]), seg7};
`else
            segNext[SEG_W*n +: SEG_W] = seg7;
`endif
        end
    end

    // Scan bus next values: the active-low one-hot anode and the matching digit code
    always_comb begin
        anNext = '1;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            anNext[n] = (scanIdx != IDX_W'(n));
        end
        scanSegNext = segNext[SEG_W*scanIdx +: SEG_W];
    end

    // Register every output.
    // The anode and segment lines update on the same edge, so no glitch appears between them.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSEG      <= '1;
            oSCAN_SEG <= '1;
            oSCAN_AN  <= '1;
        end else begin
            oSEG      <= segNext;
            oSCAN_SEG <= scanSegNext;
            oSCAN_AN  <= anNext;
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl
// Directed bench for seg7_display_ctrl with hand-computed expected codes.
// dut4 is the 4-digit instance with short scan and blink periods.
// dut6 is a 6-digit instance used for the parameter check.
`timescale 1ns/1ps
module tb_seg7_display_ctrl;

`ifdef SEG7_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif

    // Clock and shared reset
    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    // dut4 stimulus and outputs
    logic          iLOAD;
    logic [15:0]   iDIG;
    logic [3:0]    iBLANK;
    logic [3:0]    iBLINK;
    logic          iLZ_EN;
    logic [4*SW-1:0] oSEG;
    logic [SW-1:0] oSCAN_SEG;
    logic [3:0]    oSCAN_AN;

    // dut6 stimulus and outputs
    logic          load6;
    logic [23:0]   dig6;
    logic [5:0]    blank6;
    logic [5:0]    blink6;
    logic          lz6;
    logic [6*SW-1:0] oSeg6;
    logic [SW-1:0] oScanSeg6;
    logic [5:0]    oScanAn6;

`ifdef SEG7_DP_EN
    logic [3:0] dp4;
    logic [5:0] dp6;
`endif

    seg7_display_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(3), .BLINK_DIV(4)) dut4 (
        .iCLK(iCLK), .iRST(iRST), .iLOAD(iLOAD), .iDIG(iDIG),
        .iBLANK(iBLANK), .iBLINK(iBLINK), .iLZ_EN(iLZ_EN),
`ifdef SEG7_DP_EN
        .iDP(dp4),
`endif
        .oSEG(oSEG), .oSCAN_SEG(oSCAN_SEG), .oSCAN_AN(oSCAN_AN)
    );

    seg7_display_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(2), .BLINK_DIV(2)) dut6 (
        .iCLK(iCLK), .iRST(iRST), .iLOAD(load6), .iDIG(dig6),
        .iBLANK(blank6), .iBLINK(blink6), .iLZ_EN(lz6),
`ifdef SEG7_DP_EN
        .iDP(dp6),
`endif
        .oSEG(oSeg6), .oSCAN_SEG(oScanSeg6), .oSCAN_AN(oScanAn6)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queue for the scan sequence: {anode, segment}
    logic [SW+3:0] expQ[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock edge, then sample away from the edge
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Load dut4 and wait until the new data is visible on oSEG
    task automatic loadDigits(input logic [15:0] d, input logic [3:0] blank, input logic [3:0] blink);
        iDIG   = d;
        iBLANK = blank;
        iBLINK = blink;
        iLOAD  = 1'b1;
        tick();
        iLOAD = 1'b0;
        tick();
    endtask

    // Segment field with dp off, if present
    function automatic logic [SW-1:0] seg(input logic [6:0] c);
        logic [7:0] t;
        t = {1'b1, c};
        return t[SW-1:0];
    endfunction

    function automatic logic [4*SW-1:0] pack4(input logic [6:0] c3, input logic [6:0] c2,
                                              input logic [6:0] c1, input logic [6:0] c0);
        return {seg(c3), seg(c2), seg(c1), seg(c0)};
    endfunction

    initial begin
        logic [6:0]      code[4];
        logic [6*SW-1:0] exp6;
        logic [3:0]      an;
        logic [SW+3:0]   item;
        int              idx;

        // Expected codes for 16'h12AF, indexed by digit
        code[0] = 7'h0E;
        code[1] = 7'h08;
        code[2] = 7'h24;
        code[3] = 7'h79;

        iRST = 1'b1; iLOAD = 1'b0; iDIG = '0; iBLANK = '0; iBLINK = '0; iLZ_EN = 1'b0;
        load6 = 1'b0; dig6 = '0; blank6 = '0; blink6 = '0; lz6 = 1'b0;
`ifdef SEG7_DP_EN
        dp4 = '0; dp6 = '0;
`endif

        // Reset state
        tick();
        tick();
        check("rst_seg", oSEG, pack4(7'h7F, 7'h7F, 7'h7F, 7'h7F));
        check("rst_an", oSCAN_AN, 4'b1111);
        check("rst_scanseg", oSCAN_SEG, seg(7'h7F));
        check("rst_seg6", oSeg6, {6{seg(7'h7F)}});
        check("rst_an6", oScanAn6, 6'b111111);

        // Reset beats load in the same cycle
        iDIG = 16'h12AF; iBLANK = 4'h0; iLOAD = 1'b1;
        tick();
        iRST = 1'b0; iLOAD = 1'b0;
        tick();
        check("rst_over_load", oSEG, pack4(7'h7F, 7'h7F, 7'h7F, 7'h7F));

        // Load latency: unchanged right after the capture edge, new one edge later
        iDIG = 16'h12AF; iBLANK = 4'h0; iBLINK = 4'h0; iLOAD = 1'b1;
        tick();
        check("load_lat_k", oSEG, pack4(7'h7F, 7'h7F, 7'h7F, 7'h7F));
        iLOAD = 1'b0;
        tick();
        check("load_12AF", oSEG, pack4(7'h79, 7'h24, 7'h08, 7'h0E));
        iDIG = 16'h3333; iBLANK = 4'hF;
        tick();
        tick();
        check("load_hold", oSEG, pack4(7'h79, 7'h24, 7'h08, 7'h0E));

        // Leading-zero suppression
        iLZ_EN = 1'b1;
        loadDigits(16'h0005, 4'h0, 4'h0);
        check("lz_0005", oSEG, pack4(7'h7F, 7'h7F, 7'h7F, 7'h12));
        loadDigits(16'h0000, 4'h0, 4'h0);
        check("lz_0000", oSEG, pack4(7'h7F, 7'h7F, 7'h7F, 7'h40));
        loadDigits(16'h0005, 4'h0, 4'h0);
        iLZ_EN = 1'b0;
        tick();
        check("lz_off_level", oSEG, pack4(7'h40, 7'h40, 7'h40, 7'h12));
        iLZ_EN = 1'b1;
        loadDigits(16'h0105, 4'h0, 4'h0);
        check("lz_0105", oSEG, pack4(7'h7F, 7'h79, 7'h40, 7'h12));
        loadDigits(16'h1005, 4'b1000, 4'h0);
        check("lz_blank_nonzero", oSEG, pack4(7'h7F, 7'h40, 7'h40, 7'h12));
        iLZ_EN = 1'b0;

        // Six-digit instance
        dig6 = 24'hABCDEF;
`ifdef SEG7_DP_EN
        dp6 = 6'b000001;
`endif
        load6 = 1'b1;
        tick();
        load6 = 1'b0;
        tick();
        exp6 = {seg(7'h08), seg(7'h03), seg(7'h46), seg(7'h21), seg(7'h06), seg(7'h0E)};
`ifdef SEG7_DP_EN
        exp6[7] = 1'b0;
`endif
        check("p6_ABCDEF", oSeg6, exp6);

        // Blink: realign the timebase with a reset, then load on the first edge.
        // The output at edge e uses floor((e-1)/4) phase toggles.
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        iDIG = 16'h8888; iBLANK = 4'h0; iBLINK = 4'b0001; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        for (int e = 2; e <= 12; e++) begin
            tick();
            check("blink", oSEG, pack4(7'h00, 7'h00, 7'h00,
                  ((((e - 1) / 4) % 2) == 1) ? 7'h7F : 7'h00));
        end
        loadDigits(16'h8888, 4'b0001, 4'b0001);
        for (int e = 0; e < 8; e++) begin
            check("blank_over_blink", oSEG, pack4(7'h00, 7'h00, 7'h00, 7'h7F));
            tick();
        end

        // Scan sequence: each anode is held for 3 edges, and the segment bus tracks the digit
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        iDIG = 16'h12AF; iBLANK = 4'h0; iBLINK = 4'h0; iLOAD = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            idx = ((e - 1) / 3) % 4;
            an = 4'b1111;
            an[idx] = 1'b0;
            expQ.push_back({an, (e == 1) ? seg(7'h7F) : seg(code[idx])});
        end
        for (int e = 1; e <= 15; e++) begin
            tick();
            iLOAD = 1'b0;
            item = expQ.pop_front();
            check("scan_an", oSCAN_AN, item[SW+3:SW]);
            check("scan_seg", oSCAN_SEG, item[SW-1:0]);
        end

        // Reset in mid-sequence returns the index to 0
        tick();
        tick();
        iRST = 1'b1;
        tick();
        check("midrst_an", oSCAN_AN, 4'b1111);
        check("midrst_seg", oSCAN_SEG, seg(7'h7F));
        iRST = 1'b0;
        tick();
        check("midrst_an_next", oSCAN_AN, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
